// File: rtl/jbs_pkg.sv
// Shared types for the Mini-SRC jump/branch sequencer: state encoding, opcode map, strobe bundle.
package jbs_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    DONE = 4'd8,
    HALT = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_BR,
    CLS_JR,
    CLS_JAL,
    CLS_NOP,
    CLS_HALT,
    CLS_ILL
  } cls_e;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_BR   = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OPC_JAL  = 5'b10011;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;
  localparam logic [OPC_W-1:0] ALU_ADD  = 5'b00011;

  typedef struct packed {
    logic pc_in;
    logic pc_out;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_in;
    logic r_out;
    logic y_in;
    logic zlow_in;
    logic zlow_out;
    logic c_out;
    logic read;
    logic inc_pc;
    logic con_in;
    logic glr;
  } ctrl_t;

  function automatic cls_e opc_class(input logic [OPC_W-1:0] opc);
    cls_e cls;
    case (opc)
      OPC_BR:   cls = CLS_BR;
      OPC_JR:   cls = CLS_JR;
      OPC_JAL:  cls = CLS_JAL;
      OPC_NOP:  cls = CLS_NOP;
      OPC_HALT: cls = CLS_HALT;
      default:  cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/jbs_fetch_wait.sv
// Memory-wait down-counter for T1: load on T0, count down while in T1.
// expire marks the last wait cycle, first marks the first one.
module jbs_fetch_wait #(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic clear_n,
  input  logic load,
  input  logic dec,
  output logic expire,
  output logic first
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_WAIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);
  assign first  = (cnt_q == LOAD_VAL);

endmodule

// File: rtl/jump_branch_sequencer.sv
// Mini-SRC control FSM: fetch, then br/jr/jal/nop/halt with Moore-decoded datapath strobes.
// Optional JBS_PERF_CNT_EN adds saturating retired/taken counters.
module jump_branch_sequencer
  import jbs_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int OPCODE_W = 5,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic [WORD_W-1:0]   IR,
  input  logic                CON_Out,
  output logic                PCin,
  output logic                PCout,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Gra,
  output logic                Rin,
  output logic                Rout,
  output logic                Yin,
  output logic                ZLowin,
  output logic                ZLowout,
  output logic                Cout,
  output logic                Read,
  output logic                IncPC,
  output logic                CON_In,
  output logic                GLR,
  output logic [OPCODE_W-1:0] OP,
  output logic                Done,
  output logic                Illegal,
  output logic                Halted,
  output logic [3:0]          State
`ifdef JBS_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    InstrCount,
  output logic [CNT_W-1:0]    TakenCount
`endif
);

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  logic   illegal_q, illegal_d;

  logic [OPCODE_W-1:0] opc;
  cls_e                cls_now;
  logic                wait_expire;
  logic                wait_first;
  ctrl_t               ctrl;
  logic [OPCODE_W-1:0] op_sel;
  logic                unused_ir;

  assign opc       = IR[WORD_W-1 -: OPCODE_W];
  assign cls_now   = opc_class(OPC_W'(opc));
  assign unused_ir = ^IR[WORD_W-OPCODE_W-1:0];

  jbs_fetch_wait #(
    .MEM_WAIT(MEM_WAIT)
  ) u_fetch_wait (
    .clk    (Clock),
    .clear_n(Clear),
    .load   (state_q == T0),
    .dec    (state_q == T1),
    .expire (wait_expire),
    .first  (wait_first)
  );

  // Class is latched in T3 so T4 no longer depends on IR.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: if (Run) state_d = T0;
      T0:   state_d = T1;
      T1:   if (wait_expire) state_d = T2;
      T2:   state_d = T3;
      T3: begin
        cls_d     = cls_now;
        illegal_d = (cls_now == CLS_ILL);
        case (cls_now)
          CLS_BR, CLS_JAL: state_d = T4;
          CLS_HALT:        state_d = HALT;
          default:         state_d = DONE;
        endcase
      end
      T4:   state_d = (cls_q == CLS_BR) ? T5 : DONE;
      T5:   state_d = T6;
      T6:   state_d = DONE;
      DONE: state_d = Run ? T0 : IDLE;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q   <= IDLE;
      cls_q     <= CLS_NOP;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ctrl   = '0;
    op_sel = '0;
    case (state_q)
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
      end
      T1: begin
        ctrl.read   = 1'b1;
        ctrl.mdr_in = 1'b1;
        ctrl.inc_pc = wait_first;
      end
      T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      T3: begin
        case (cls_now)
          CLS_BR: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.con_in = 1'b1;
          end
          CLS_JR: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_in = 1'b1;
          end
          CLS_JAL: begin
            ctrl.pc_out = 1'b1;
            ctrl.r_in   = 1'b1;
            ctrl.glr    = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (cls_q == CLS_BR) begin
          ctrl.pc_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end else begin
          ctrl.gra   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.pc_in = 1'b1;
        end
      end
      T5: begin
        ctrl.c_out   = 1'b1;
        ctrl.zlow_in = 1'b1;
        op_sel       = OPCODE_W'(ALU_ADD);
      end
      T6: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = CON_Out;
      end
      default: ;
    endcase
  end

  assign PCin    = ctrl.pc_in;
  assign PCout   = ctrl.pc_out;
  assign MARin   = ctrl.mar_in;
  assign MDRin   = ctrl.mdr_in;
  assign MDRout  = ctrl.mdr_out;
  assign IRin    = ctrl.ir_in;
  assign Gra     = ctrl.gra;
  assign Rin     = ctrl.r_in;
  assign Rout    = ctrl.r_out;
  assign Yin     = ctrl.y_in;
  assign ZLowin  = ctrl.zlow_in;
  assign ZLowout = ctrl.zlow_out;
  assign Cout    = ctrl.c_out;
  assign Read    = ctrl.read;
  assign IncPC   = ctrl.inc_pc;
  assign CON_In  = ctrl.con_in;
  assign GLR     = ctrl.glr;
  assign OP      = op_sel;
  assign Done    = (state_q == DONE);
  assign Illegal = (state_q == DONE) && illegal_q;
  assign Halted  = (state_q == HALT);
  assign State   = state_q;

`ifdef JBS_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             taken_evt;

  assign taken_evt = ((state_q == T6) && CON_Out) ||
                     ((state_q == T3) && (cls_now == CLS_JR)) ||
                     ((state_q == T4) && (cls_q == CLS_JAL));

  // Counters hold at all-ones instead of wrapping.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if ((state_q == DONE) && !(&instr_cnt_q)) instr_cnt_d = instr_cnt_q + 1'b1;
    if (taken_evt && !(&taken_cnt_q))         taken_cnt_d = taken_cnt_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      instr_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign InstrCount = instr_cnt_q;
  assign TakenCount = taken_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_jump_branch_sequencer.sv
// Drives a MEM_WAIT=1 and a MEM_WAIT=3 sequencer in lockstep and scores every cycle against a per-cycle model.
module tb_jump_branch_sequencer;
  import jbs_pkg::*;

  localparam int B_PCIN = 16, B_PCOUT = 15, B_MARIN = 14, B_MDRIN = 13, B_MDROUT = 12;
  localparam int B_IRIN = 11, B_GRA = 10, B_RIN = 9, B_ROUT = 8, B_YIN = 7, B_ZIN = 6;
  localparam int B_ZOUT = 5, B_COUT = 4, B_READ = 3, B_INCPC = 2, B_CONIN = 1, B_GLR = 0;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Run   = 1'b0;
  logic [31:0] IR    = '0;
  logic        CON_Out = 1'b0;

  wire [16:0] stb1, stb3;
  wire [4:0]  op1, op3;
  wire        dn1, dn3, il1, il3, hl1, hl3;
  wire [3:0]  st1, st3;
`ifdef JBS_PERF_CNT_EN
  wire [15:0] ic1, tc1;
  wire [1:0]  ic3, tc3;
`endif

  logic [28:0] obs1, obs3;
  assign obs1 = {st1, op1, dn1, il1, hl1, stb1};
  assign obs3 = {st3, op3, dn3, il3, hl3, stb3};

  logic [28:0] q1[$];
  logic [28:0] q3[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  jump_branch_sequencer #(.MEM_WAIT(1), .CNT_W(16)) u_dut1 (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .CON_Out(CON_Out),
    .PCin(stb1[B_PCIN]), .PCout(stb1[B_PCOUT]), .MARin(stb1[B_MARIN]), .MDRin(stb1[B_MDRIN]),
    .MDRout(stb1[B_MDROUT]), .IRin(stb1[B_IRIN]), .Gra(stb1[B_GRA]), .Rin(stb1[B_RIN]),
    .Rout(stb1[B_ROUT]), .Yin(stb1[B_YIN]), .ZLowin(stb1[B_ZIN]), .ZLowout(stb1[B_ZOUT]),
    .Cout(stb1[B_COUT]), .Read(stb1[B_READ]), .IncPC(stb1[B_INCPC]), .CON_In(stb1[B_CONIN]),
    .GLR(stb1[B_GLR]), .OP(op1), .Done(dn1), .Illegal(il1), .Halted(hl1), .State(st1)
`ifdef JBS_PERF_CNT_EN
    , .InstrCount(ic1), .TakenCount(tc1)
`endif
  );

  jump_branch_sequencer #(.MEM_WAIT(3), .CNT_W(2)) u_dut3 (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .CON_Out(CON_Out),
    .PCin(stb3[B_PCIN]), .PCout(stb3[B_PCOUT]), .MARin(stb3[B_MARIN]), .MDRin(stb3[B_MDRIN]),
    .MDRout(stb3[B_MDROUT]), .IRin(stb3[B_IRIN]), .Gra(stb3[B_GRA]), .Rin(stb3[B_RIN]),
    .Rout(stb3[B_ROUT]), .Yin(stb3[B_YIN]), .ZLowin(stb3[B_ZIN]), .ZLowout(stb3[B_ZOUT]),
    .Cout(stb3[B_COUT]), .Read(stb3[B_READ]), .IncPC(stb3[B_INCPC]), .CON_In(stb3[B_CONIN]),
    .GLR(stb3[B_GLR]), .OP(op3), .Done(dn3), .Illegal(il3), .Halted(hl3), .State(st3)
`ifdef JBS_PERF_CNT_EN
    , .InstrCount(ic3), .TakenCount(tc3)
`endif
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output vector for cycle k after Run is applied; Clear before edge clear_at forces IDLE.
  function automatic logic [28:0] exp_at(input int mw, input logic [4:0] opc, input bit con,
                                         input int k, input int clear_at);
    state_e      st;
    logic [16:0] s;
    logic [4:0]  op;
    bit          dn, il, hl;
    bit          first;
    int          t3, j;
    s = '0; op = '0; dn = 0; il = 0; hl = 0; first = 0; st = IDLE;
    t3 = 3 + mw;
    if (k >= clear_at)       st = IDLE;
    else if (k == 1)         st = T0;
    else if (k <= 1 + mw) begin st = T1; first = (k == 2); end
    else if (k == t3 - 1)    st = T2;
    else if (k == t3)        st = T3;
    else begin
      j = k - t3;
      case (opc)
        5'b10010: st = (j == 1) ? T4 : (j == 2) ? T5 : (j == 3) ? T6 : (j == 4) ? DONE : IDLE;
        5'b10011: st = (j == 1) ? T4 : (j == 2) ? DONE : IDLE;
        5'b11011: st = HALT;
        default:  st = (j == 1) ? DONE : IDLE;
      endcase
    end
    case (st)
      T0: begin s[B_PCOUT] = 1; s[B_MARIN] = 1; end
      T1: begin s[B_READ] = 1; s[B_MDRIN] = 1; s[B_INCPC] = first; end
      T2: begin s[B_MDROUT] = 1; s[B_IRIN] = 1; end
      T3: begin
        if (opc == 5'b10010) begin s[B_GRA] = 1; s[B_ROUT] = 1; s[B_CONIN] = 1; end
        if (opc == 5'b10100) begin s[B_GRA] = 1; s[B_ROUT] = 1; s[B_PCIN] = 1; end
        if (opc == 5'b10011) begin s[B_PCOUT] = 1; s[B_RIN] = 1; s[B_GLR] = 1; end
      end
      T4: begin
        if (opc == 5'b10010) begin s[B_PCOUT] = 1; s[B_YIN] = 1; end
        else begin s[B_GRA] = 1; s[B_ROUT] = 1; s[B_PCIN] = 1; end
      end
      T5: begin s[B_COUT] = 1; s[B_ZIN] = 1; op = 5'b00011; end
      T6: begin s[B_ZOUT] = 1; s[B_PCIN] = con; end
      DONE: begin
        dn = 1;
        il = !(opc inside {5'b10010, 5'b10100, 5'b10011, 5'b11010, 5'b11011});
      end
      HALT: hl = 1;
      default: ;
    endcase
    return {4'(st), op, dn, il, hl, s};
  endfunction

  task automatic run_case(input string name, input logic [4:0] opc, input bit con,
                          input bit hold_run, input int clear_at, input int ncyc);
    logic [28:0] e;
    for (int k = 1; k <= ncyc; k++) begin
      q1.push_back(exp_at(1, opc, con, k, clear_at));
      q3.push_back(exp_at(3, opc, con, k, clear_at));
    end
    IR      = {opc, 27'h1000000};
    CON_Out = con;
    Run     = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == clear_at) begin
        Clear = 1'b0;
        Run   = 1'b0;
      end
      @(posedge Clock);
      #1;
      Clear = 1'b1;
      if (!hold_run) Run = 1'b0;
      if (q1.size() == 0 || q3.size() == 0) begin
        chk_eq($sformatf("%s/queue_empty/k%0d", name, k), 64'd0, 64'd1);
      end else begin
        e = q1.pop_front();
        chk_eq($sformatf("%s/mw1/k%0d", name, k), 64'(obs1), 64'(e));
        e = q3.pop_front();
        chk_eq($sformatf("%s/mw3/k%0d", name, k), 64'(obs3), 64'(e));
      end
    end
    Run = 1'b0;
  endtask

`ifdef JBS_PERF_CNT_EN
  int m_instr = 0;
  int m_taken = 0;
  task automatic chk_cnt(input string name);
    chk_eq({name, "/instr1"}, 64'(ic1), 64'(m_instr));
    chk_eq({name, "/taken1"}, 64'(tc1), 64'(m_taken));
    chk_eq({name, "/instr3"}, 64'(ic3), 64'((m_instr > 3) ? 3 : m_instr));
    chk_eq({name, "/taken3"}, 64'(tc3), 64'((m_taken > 3) ? 3 : m_taken));
  endtask
`endif

  initial begin
    Clear = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk_eq("reset/mw1", 64'(obs1), 64'(exp_at(1, 5'b0, 1'b0, 1, 0)));
    chk_eq("reset/mw3", 64'(obs3), 64'(exp_at(3, 5'b0, 1'b0, 1, 0)));
    Clear = 1'b1;
    @(posedge Clock);
    #1;
`ifdef JBS_PERF_CNT_EN
    chk_cnt("cnt_reset");
`endif

    run_case("jr",       5'b10100, 1'b0, 1'b0, 99, 12);
    run_case("br_taken", 5'b10010, 1'b1, 1'b0, 99, 12);
    run_case("br_not",   5'b10010, 1'b0, 1'b0, 99, 12);
    run_case("jal",      5'b10011, 1'b0, 1'b0, 99, 12);
    run_case("nop",      5'b11010, 1'b1, 1'b0, 99, 12);
    run_case("illegal",  5'b11111, 1'b0, 1'b0, 99, 12);
`ifdef JBS_PERF_CNT_EN
    m_instr = 6;
    m_taken = 3;
    chk_cnt("cnt_after6");
`endif
    run_case("halt",     5'b11011, 1'b0, 1'b1, 11, 12);
`ifdef JBS_PERF_CNT_EN
    m_instr = 0;
    m_taken = 0;
    chk_cnt("cnt_after_clear");
`endif
    run_case("clr_t5",   5'b10010, 1'b1, 1'b0, 7, 9);
    run_case("clr_wait", 5'b10011, 1'b0, 1'b0, 3, 6);
    run_case("jr_again", 5'b10100, 1'b0, 1'b0, 99, 12);
`ifdef JBS_PERF_CNT_EN
    m_instr = 1;
    m_taken = 1;
    chk_cnt("cnt_final");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jump_branch_sequencer.md
Name: jump_branch_sequencer

Overview:
- Synchronous control sequencer for the Mini-SRC datapath. Replaces hand-driven T-state control with an FSM.
- Runs instruction fetch, then the control-transfer class: br (with condition), jr, jal, plus nop, halt and illegal-opcode handling.
- Drives the same control strobes the datapath already accepts: PCin, PCout, MARin, MDRin, MDRout, IRin, Gra, Rin, Rout, Yin, ZLowin, ZLowout, Cout, Read, IncPC, CON_In, GLR and OP.

Parameters:
- WORD_W, 32, IR width.
- OPCODE_W, 5, width of opcode field IR[WORD_W-1 -: OPCODE_W] and of OP.
- MEM_WAIT, 1, cycles Read/MDRin stay asserted in T1; must be at least 1.
- CNT_W, 16, width of the performance counters (PERF_CNT_EN only).

Ports:
- Clock, in, 1, system clock; all state changes on posedge.
- Clear, in, 1, synchronous active-low reset.
- Run, in, 1, start/continue request, sampled in IDLE.
- IR, in, WORD_W, datapath IR contents.
- CON_Out, in, 1, branch condition result from the CON FF.
- PCin, PCout, MARin, MDRin, MDRout, IRin, Gra, Rin, Rout, Yin, ZLowin, ZLowout, Cout, Read, IncPC, CON_In, GLR: out, 1 each, datapath control strobes.
- OP, out, OPCODE_W, ALU operation select.
- Done, out, 1, one-cycle pulse when an instruction retires.
- Illegal, out, 1, one-cycle pulse together with Done when the opcode is unsupported.
- Halted, out, 1, level; high in HALT.
- State, out, 4, current state encoding, for debug.

Behaviour:
- Reset: Clear=0 at posedge forces IDLE. All strobes, Done, Illegal and Halted go to 0, and OP goes to 0. Clear overrides any state, including mid-T1 wait and HALT.
- All outputs are registered-state decoded (Moore). Each strobe is high for every cycle the FSM is in its state.
- IDLE: if Run=1, go to T0; otherwise stay.
- T0: PCout, MARin. Go to T1.
- T1: Read and MDRin for MEM_WAIT cycles, counted by an internal wait counter. IncPC is high on the first T1 cycle only. Go to T2 when the counter expires.
- T2: MDRout, IRin. Go to T3. IR is valid from T3 onward.
- T3 decode, on opcode = IR[WORD_W-1 -: OPCODE_W]:
  - br (10010): Gra, Rout, CON_In. Go to T4.
  - jr (10100): Gra, Rout, PCin. Go to DONE.
  - jal (10011): PCout, Rin, GLR (link into R15). Go to T4.
  - nop (11010): go to DONE.
  - halt (11011): go to HALT.
  - any other opcode: go to DONE with Illegal asserted there.
- T4:
  - br: PCout, Yin. Go to T5.
  - jal: Gra, Rout, PCin. Go to DONE.
- T5 (br): Cout, OP=ALU_ADD, ZLowin. Go to T6.
- T6 (br): ZLowout. PCin = CON_Out, sampled combinationally in T6. Go to DONE.
- DONE: Done=1. Go to T0 if Run=1, else IDLE.
- HALT: Halted=1. Exits only via Clear.
- Run deasserted mid-instruction has no effect; the instruction completes.
- jal with Ra=R15: link is written in T3 and read in T4, so PC receives the new link value. This is intentional and documented.
- Latency, Run to Done: jr = 4+MEM_WAIT cycles; jal = 5+MEM_WAIT; br = 7+MEM_WAIT; nop/illegal = 4+MEM_WAIT.

Optional Feature:
- Macro: JBS_PERF_CNT_EN.
- With the macro:
  - Adds outputs InstrCount[CNT_W] and TakenCount[CNT_W], both reset to 0 on Clear.
  - InstrCount increments in every DONE.
  - TakenCount increments in T6 when CON_Out=1, and in T3 for jr and T4 for jal.
  - Both counters saturate at all-ones; they do not wrap.
- Without the macro: the ports and logic are absent.

Decomposition:
- Package jbs_pkg holds:
  - state enum: IDLE, T0-T6, DONE, HALT;
  - opcode constants OPC_BR, OPC_JR, OPC_JAL, OPC_NOP, OPC_HALT;
  - ALU_ADD=5'b00011.
- One sub-module, jbs_fetch_wait: the MEM_WAIT down-counter, with load and expire signals.

Test Plan:
- IR=32'hA1000000 (jr R2), MEM_WAIT=1: T3 shows Gra=Rout=PCin=1; Done at cycle 5 after Run; Illegal=0.
- br taken: opcode 10010, CON_Out=1 in T6: CON_In high in T3, OP=ALU_ADD in T5, PCin=1 in T6, Done at cycle 8.
- br not taken: same IR, CON_Out=0: PCin stays 0 throughout T6; Done still at cycle 8.
- jal: T3 has PCout=Rin=GLR=1; T4 has Gra=Rout=PCin=1; Done at cycle 6. With MEM_WAIT=3, Read is high for exactly 3 cycles and IncPC for 1 cycle.
- IR opcode 11111: Done and Illegal pulse together. IR opcode 11011: Halted=1 persists with Run=1, until Clear=0, which returns IDLE with all outputs 0.
- Clear=0 during the T1 wait and during T5: next state is IDLE with all strobes 0. With JBS_PERF_CNT_EN, the counters read 0 afterwards and saturate at 16'hFFFF when forced.
